// File: rtl/uart_tx_framer.sv
// Queues ALU results and sends each as a UART frame {2'b01,op}, result [, hdr^result when UART_TX_FRAMER_CHK_EN]; first o_tx_start 3 cycles after i_valid.
// No backpressure: results arriving while the DEPTH-entry FIFO is full are dropped and raise sticky o_overflow.
module uart_tx_framer #(
   parameter int NB_DATA = 8,
   parameter int NB_OP   = 6,
   parameter int DEPTH   = 4
) (
   input  logic               clk,
   input  logic               i_rst,
   input  logic               i_valid,
   input  logic [NB_DATA-1:0] i_result,
   input  logic [NB_OP-1:0]   i_operation,
   input  logic               i_txDone,
   output logic               o_tx_start,
   output logic [NB_DATA-1:0] o_data,
   output logic               o_busy,
   output logic               o_full,
   output logic               o_overflow
);

   localparam int          AW        = $clog2(DEPTH);
   localparam int          EW        = NB_OP + NB_DATA;
   localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_LOAD = 2'd1;
   localparam logic [1:0] ST_SEND = 2'd2;
   localparam logic [1:0] ST_WAIT = 2'd3;

`ifdef UART_TX_FRAMER_CHK_EN
   localparam logic [1:0] LAST_IDX = 2'd2;
`else
   localparam logic [1:0] LAST_IDX = 2'd1;
`endif

   logic [EW-1:0]      mem_q [DEPTH];
   logic [AW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0]        cnt_q, cnt_d;
   logic               ovf_q, ovf_d;
   logic [1:0]         state_q, state_d;
   logic [1:0]         idx_q, idx_d;
   logic [NB_OP-1:0]   op_q, op_d;
   logic [NB_DATA-1:0] res_q, res_d;
   logic [NB_DATA-1:0] data_q, data_d;
   logic               full, empty, push, pop;
   logic [NB_OP-1:0]   head_op;
   logic [NB_DATA-1:0] head_res;

   assign full  = (cnt_q == DEPTH_CNT);
   assign empty = (cnt_q == '0);
   // A pop in the same cycle never frees room for a write that found the FIFO full.
   assign push  = i_valid & ~full;
   assign pop   = (state_q == ST_IDLE) & ~empty;
   assign {head_op, head_res} = mem_q[rd_ptr_q];

   function automatic logic [NB_DATA-1:0] frame_byte(input logic [1:0]         idx,
                                                     input logic [NB_OP-1:0]   op,
                                                     input logic [NB_DATA-1:0] res);
      logic [NB_DATA-1:0] hdr;
      hdr        = {2'b01, op};
      frame_byte = res;
      if (idx == 2'd0) frame_byte = hdr;
`ifdef UART_TX_FRAMER_CHK_EN
      if (idx == 2'd2) frame_byte = hdr ^ res;
`endif
   endfunction

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      ovf_d    = ovf_q;
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (push & ~pop)      cnt_d = cnt_q + (AW+1)'(1);
      else if (pop & ~push) cnt_d = cnt_q - (AW+1)'(1);
      if (i_valid & full) ovf_d = 1'b1;
   end

   // o_data is loaded on entry to LOAD so it is already valid in LOAD and holds through WAIT.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      op_d    = op_q;
      res_d   = res_q;
      data_d  = data_q;
      case (state_q)
         ST_IDLE: begin
            if (!empty) begin
               op_d    = head_op;
               res_d   = head_res;
               idx_d   = 2'd0;
               data_d  = frame_byte(2'd0, head_op, head_res);
               state_d = ST_LOAD;
            end
         end
         ST_LOAD: state_d = ST_SEND;
         ST_SEND: state_d = ST_WAIT;
         ST_WAIT: begin
            if (i_txDone) begin
               if (idx_q == LAST_IDX) begin
                  state_d = ST_IDLE;
               end else begin
                  idx_d   = idx_q + 2'd1;
                  data_d  = frame_byte(idx_q + 2'd1, op_q, res_q);
                  state_d = ST_LOAD;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (i_rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         ovf_q    <= 1'b0;
         state_q  <= ST_IDLE;
         idx_q    <= '0;
         op_q     <= '0;
         res_q    <= '0;
         data_q   <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         ovf_q    <= ovf_d;
         state_q  <= state_d;
         idx_q    <= idx_d;
         op_q     <= op_d;
         res_q    <= res_d;
         data_q   <= data_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= {i_operation, i_result};
   end

   assign o_tx_start = (state_q == ST_SEND);
   assign o_data     = data_q;
   // Busy also covers the single IDLE cycle in which a queued result is being popped.
   assign o_busy     = (state_q != ST_IDLE) | ~empty;
   assign o_full     = full;
   assign o_overflow = ovf_q;

endmodule

// File: tb/tb_uart_tx_framer.sv
// Bench for uart_tx_framer: queue-based frame model checked every cycle, plus directed literal checks.
module tb_uart_tx_framer;

   localparam int NB_DATA = 8;
   localparam int NB_OP   = 6;
   localparam int DEPTH   = 4;
`ifdef UART_TX_FRAMER_CHK_EN
   localparam int NBYTES = 3;
`else
   localparam int NBYTES = 2;
`endif

   logic               clk = 1'b0;
   logic               i_rst, i_valid, i_txDone;
   logic [NB_DATA-1:0] i_result;
   logic [NB_OP-1:0]   i_operation;
   logic               o_tx_start, o_busy, o_full, o_overflow;
   logic [NB_DATA-1:0] o_data;

   uart_tx_framer #(.NB_DATA(NB_DATA), .NB_OP(NB_OP), .DEPTH(DEPTH)) dut (
      .clk        (clk),
      .i_rst      (i_rst),
      .i_valid    (i_valid),
      .i_result   (i_result),
      .i_operation(i_operation),
      .i_txDone   (i_txDone),
      .o_tx_start (o_tx_start),
      .o_data     (o_data),
      .o_busy     (o_busy),
      .o_full     (o_full),
      .o_overflow (o_overflow)
   );

   always #5 clk = ~clk;

   int cyc      = 0;
   int n_chk    = 0;
   int n_fail   = 0;
   bit chk_en   = 0;
   bit auto_done = 0;
   bit rand_dly = 0;
   int done_due = -1;

   typedef struct {int c; logic [NB_DATA-1:0] d;} start_t;
   start_t log_q[$];

   // Model: pending results, bytes left in the frame on the wire, and the cycle of the next start.
   logic [NB_OP+NB_DATA-1:0] m_q[$];
   logic [NB_DATA-1:0]       m_bytes[$];
   logic [NB_DATA-1:0]       m_cur;
   bit m_active = 0, m_waiting = 0, m_ovf = 0, m_zero = 0;
   int m_next = -1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   initial forever begin
      logic [NB_OP+NB_DATA-1:0] e;
      logic [NB_DATA-1:0]       hdr;
      bit                       idle_now, full_now;
      @(posedge clk);
      if (i_rst) begin
         m_q.delete();
         m_bytes.delete();
         m_active  = 0;
         m_waiting = 0;
         m_ovf     = 0;
         m_zero    = 1;
         m_next    = -1;
      end else begin
         idle_now = !m_active;
         full_now = (m_q.size() == DEPTH);
         if (m_waiting && i_txDone) begin
            m_waiting = 0;
            if (m_bytes.size() > 0) m_next = cyc + 2;
            else m_active = 0;
         end
         if (cyc == m_next) begin
            m_cur     = m_bytes.pop_front();
            m_waiting = 1;
            m_next    = -1;
         end
         if (idle_now && m_q.size() > 0) begin
            e   = m_q.pop_front();
            hdr = {2'b01, e[NB_OP+NB_DATA-1 -: NB_OP]};
            m_bytes.push_back(hdr);
            m_bytes.push_back(e[NB_DATA-1:0]);
`ifdef UART_TX_FRAMER_CHK_EN
            m_bytes.push_back(hdr ^ e[NB_DATA-1:0]);
`endif
            m_active = 1;
            m_zero   = 0;
            m_next   = cyc + 2;
         end
         if (i_valid) begin
            if (full_now) m_ovf = 1;
            else m_q.push_back({i_operation, i_result});
         end
      end
      cyc = cyc + 1;
   end

   initial forever begin
      @(negedge clk);
      if (chk_en) begin
         chk("tx_start", {31'd0, o_tx_start}, {31'd0, cyc == m_next});
         if (cyc == m_next) chk("data_at_start", o_data, m_bytes[0]);
         if (m_next == cyc + 1) chk("data_at_load", o_data, m_bytes[0]);
         if (m_waiting) chk("data_hold", o_data, m_cur);
         if (m_zero) chk("data_after_reset", o_data, 0);
         chk("busy", {31'd0, o_busy}, {31'd0, m_active || m_q.size() > 0});
         chk("full", {31'd0, o_full}, {31'd0, m_q.size() == DEPTH});
         chk("overflow", {31'd0, o_overflow}, {31'd0, m_ovf});
         if (o_tx_start === 1'b1) begin
            log_q.push_back('{c: cyc, d: o_data});
            done_due = cyc + (rand_dly ? int'($urandom_range(14, 1)) : 10);
         end
      end
   end

   task automatic tick(input bit v, input logic [NB_OP-1:0] op, input logic [NB_DATA-1:0] res,
                       input bit rst, input bit stray);
      @(negedge clk);
      #1;
      i_valid     = v;
      i_operation = op;
      i_result    = res;
      i_rst       = rst;
      i_txDone    = stray | (auto_done && cyc == done_due);
   endtask

   task automatic wait_idle(input int budget);
      int n;
      n = 0;
      do begin
         tick(0, '0, '0, 0, 0);
         n++;
      end while (o_busy && n < budget);
      chk("drain_done", {31'd0, o_busy}, 32'd0);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int vc;
      i_rst = 1; i_valid = 0; i_txDone = 0; i_result = '0; i_operation = '0;
      tick(0, '0, '0, 1, 0);
      tick(0, '0, '0, 1, 0);
      chk_en = 1;
      chk("rst_busy", {31'd0, o_busy}, 32'd0);
      chk("rst_start", {31'd0, o_tx_start}, 32'd0);
      chk("rst_data", o_data, 32'd0);
      chk("rst_full", {31'd0, o_full}, 32'd0);
      chk("rst_ovf", {31'd0, o_overflow}, 32'd0);
      tick(0, '0, '0, 0, 0);

      // Single frame op=02 result=3C: latency, bytes and spacing.
      auto_done = 1;
      log_q.delete();
      tick(1, 6'h02, 8'h3C, 0, 0);
      vc = cyc;
      chk("busy_at_valid", {31'd0, o_busy}, 32'd0);
      tick(0, '0, '0, 0, 0);
      chk("busy_after_valid", {31'd0, o_busy}, 32'd1);
      wait_idle(200);
      chk("frame_bytes", log_q.size(), NBYTES);
      if (log_q.size() >= NBYTES) begin
         chk("latency", log_q[0].c, vc + 3);
         chk("header", log_q[0].d, 8'h42);
         chk("result", log_q[1].d, 8'h3C);
         chk("byte_spacing", log_q[1].c - log_q[0].c, 12);
`ifdef UART_TX_FRAMER_CHK_EN
         chk("checksum", log_q[2].d, 8'h7E);
`endif
      end

      // Stray txDone in IDLE and LOAD.
      log_q.delete();
      tick(0, '0, '0, 0, 1);
      tick(0, '0, '0, 0, 1);
      chk("stray_idle_busy", {31'd0, o_busy}, 32'd0);
      tick(1, 6'h15, 8'hA5, 0, 0);
      vc = cyc;
      tick(0, '0, '0, 0, 0);
      tick(0, '0, '0, 0, 1);
      wait_idle(200);
      chk("stray_bytes", log_q.size(), NBYTES);
      if (log_q.size() > 0) chk("stray_latency", log_q[0].c, vc + 3);

      // Overflow: hold the transmitter in WAIT, then push DEPTH+1 results.
      log_q.delete();
      auto_done = 0;
      tick(1, 6'h01, 8'h11, 0, 0);
      repeat (3) tick(0, '0, '0, 0, 0);
      for (int i = 0; i <= DEPTH; i++) begin
         tick(1, NB_OP'(i + 8), NB_DATA'(i * 16 + 3), 0, 0);
         if (i == DEPTH) begin
            chk("full_after_depth", {31'd0, o_full}, 32'd1);
            chk("ovf_before_drop", {31'd0, o_overflow}, 32'd0);
         end
      end
      tick(0, '0, '0, 0, 0);
      chk("ovf_set", {31'd0, o_overflow}, 32'd1);
      chk("full_held", {31'd0, o_full}, 32'd1);
      auto_done = 1;
      tick(0, '0, '0, 0, 1);
      wait_idle(2000);
      chk("ovf_frames", log_q.size(), (DEPTH + 1) * NBYTES);
      chk("ovf_sticky", {31'd0, o_overflow}, 32'd1);
      if (log_q.size() > DEPTH * NBYTES) chk("last_kept_hdr", log_q[DEPTH*NBYTES].d, 8'h4B);

      // Reset while waiting on byte1.
      tick(0, '0, '0, 1, 0);
      tick(0, '0, '0, 0, 0);
      log_q.delete();
      tick(1, 6'h2A, 8'h5A, 0, 0);
      for (int n = 0; n < 100 && log_q.size() < 2; n++) tick(0, '0, '0, 0, 0);
      chk("byte1_started", log_q.size(), 2);
      auto_done = 0;
      repeat (3) tick(0, '0, '0, 0, 0);
      tick(0, '0, '0, 1, 0);
      tick(0, '0, '0, 0, 0);
      chk("midrst_busy", {31'd0, o_busy}, 32'd0);
      chk("midrst_data", o_data, 32'd0);
      chk("midrst_full", {31'd0, o_full}, 32'd0);
      chk("midrst_ovf", {31'd0, o_overflow}, 32'd0);
      tick(0, '0, '0, 0, 1);
      repeat (20) tick(0, '0, '0, 0, 0);
      chk("no_start_after_rst", log_q.size(), 2);

      // Pointer wrap: 3*DEPTH frames, one at a time.
      auto_done = 1;
      log_q.delete();
      for (int i = 0; i < 3 * DEPTH; i++) begin
         tick(1, NB_OP'($urandom), NB_DATA'($urandom), 0, 0);
         tick(0, '0, '0, 0, 0);
         wait_idle(200);
      end
      chk("wrap_bytes", log_q.size(), 3 * DEPTH * NBYTES);

      // Random traffic with random turnaround, stray txDone and occasional reset.
      rand_dly = 1;
      repeat (1500) begin
         tick($urandom_range(5, 0) == 0, NB_OP'($urandom), NB_DATA'($urandom),
              $urandom_range(399, 0) == 0, $urandom_range(59, 0) == 0);
      end
      wait_idle(3000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
